// File: rtl/instr_mem_arbiter.sv
// Instruction memory arbiter: shares one memory port between CPU fetch
// and program-loader writes with alternating priority on conflict.
//
// Ports:
//   CLK, RESET          clock (rising edge), async active-high reset
//   CPU_READ/ADDRESS    CPU fetch request and byte address
//   CPU_READDATA        fetched word, updated when a read completes
//   CPU_BUSYWAIT        CPU stall
//   LD_WRITE/ADDRESS    loader write request and byte address
//   LD_WRITEDATA        loader word
//   LD_BUSYWAIT         loader stall
//   MEM_READ/WRITE      memory strobes
//   MEM_ADDRESS         word-aligned memory address (latched at grant)
//   MEM_WRITEDATA       memory write word (latched at grant)
//   MEM_READDATA        memory read word
//   MEM_BUSYWAIT        memory not ready
module instr_mem_arbiter (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_READ,
    input  logic [31:0] CPU_ADDRESS,
    output logic [31:0] CPU_READDATA,
    output logic        CPU_BUSYWAIT,
    input  logic        LD_WRITE,
    input  logic [31:0] LD_ADDRESS,
    input  logic [31:0] LD_WRITEDATA,
    output logic        LD_BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [31:0] MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        LD_ACC,
        CPU_DONE,
        LD_DONE
    } state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_LD  = 1'b1;

    state_t      state;
    state_t      next_state;
    logic        last_grant;
    logic        next_last_grant;
    logic        grant_cpu;
    logic        grant_ld;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] cpu_word;
    logic [31:0] ld_word;

    assign cpu_word = CPU_ADDRESS & 32'hFFFF_FFFC;
    assign ld_word  = LD_ADDRESS & 32'hFFFF_FFFC;

    always_comb begin
        next_state      = state;
        next_last_grant = last_grant;
        grant_cpu       = 1'b0;
        grant_ld        = 1'b0;
        case (state)
            IDLE: begin
                // On conflict the side that did not win last time goes first.
                if (CPU_READ && LD_WRITE) begin
                    if (last_grant == GRANT_LD) grant_cpu = 1'b1;
                    else                        grant_ld  = 1'b1;
                end else if (CPU_READ) begin
                    grant_cpu = 1'b1;
                end else if (LD_WRITE) begin
                    grant_ld = 1'b1;
                end
                if (grant_cpu) next_state = CPU_ACC;
                if (grant_ld)  next_state = LD_ACC;
            end
            CPU_ACC: begin
                if (!MEM_BUSYWAIT) begin
                    next_state      = CPU_DONE;
                    next_last_grant = GRANT_CPU;
                end
            end
            LD_ACC: begin
                if (!MEM_BUSYWAIT) begin
                    next_state      = LD_DONE;
                    next_last_grant = GRANT_LD;
                end
            end
            // DONE always returns to IDLE so a held request is re-arbitrated.
            CPU_DONE: next_state = IDLE;
            LD_DONE:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            last_grant <= GRANT_LD;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
            if (grant_cpu) begin
                addr_q  <= cpu_word;
                wdata_q <= LD_WRITEDATA;
            end
            if (grant_ld) begin
                addr_q  <= ld_word;
                wdata_q <= LD_WRITEDATA;
            end
            if (state == CPU_ACC && !MEM_BUSYWAIT) begin
                rdata_q <= MEM_READDATA;
            end
        end
    end

    assign MEM_READ      = (state == CPU_ACC);
    assign MEM_WRITE     = (state == LD_ACC);
    assign MEM_ADDRESS   = addr_q;
    assign MEM_WRITEDATA = wdata_q;
    assign CPU_READDATA  = rdata_q;
    assign CPU_BUSYWAIT  = CPU_READ && (state != CPU_DONE);
    assign LD_BUSYWAIT   = LD_WRITE && (state != LD_DONE);

endmodule

// File: doc/instr_mem_arbiter.md
INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset, named CLK and RESET as elsewhere in the codebase.
REQ-002 SHALL have ports (name  direction  width  meaning):
  CLK  input  1  clock, rising-edge active.
  RESET  input  1  asynchronous, active-high reset.
  CPU_READ  input  1  CPU fetch request, held until CPU_BUSYWAIT is low.
  CPU_ADDRESS  input  32  CPU byte address.
  CPU_READDATA  output  32  fetched instruction word.
  CPU_BUSYWAIT  output  1  CPU stall.
  LD_WRITE  input  1  program-loader write request, held until LD_BUSYWAIT is low.
  LD_ADDRESS  input  32  loader byte address.
  LD_WRITEDATA  input  32  loader word.
  LD_BUSYWAIT  output  1  loader stall.
  MEM_READ  output  1  memory read strobe.
  MEM_WRITE  output  1  memory write strobe.
  MEM_ADDRESS  output  32  word-aligned memory address.
  MEM_WRITEDATA  output  32  memory write word.
  MEM_READDATA  input  32  memory read word.
  MEM_BUSYWAIT  input  1  memory not ready.
REQ-003 SHALL have no parameters.

Function
REQ-004 SHALL implement an FSM with states IDLE, CPU_ACC, LD_ACC, CPU_DONE and LD_DONE.
REQ-005 In IDLE with exactly one request pending, SHALL enter the matching *_ACC state on the next edge.
REQ-006 In IDLE with both requests pending, SHALL grant the requester not in last_grant, a 1-bit register that reset sets to LOADER so the CPU wins the first conflict.
REQ-007 On a grant, SHALL latch {addr[31:2],2'b00} and LD_WRITEDATA into internal registers; MEM_ADDRESS and MEM_WRITEDATA SHALL be driven only from these latches.
REQ-008 SHALL assert MEM_READ only in CPU_ACC and MEM_WRITE only in LD_ACC; the two SHALL never be high together.
REQ-009 In *_ACC, SHALL hold the state while MEM_BUSYWAIT=1; on an edge with MEM_BUSYWAIT=0, SHALL move to the matching *_DONE state and update last_grant.
REQ-010 On CPU_ACC->CPU_DONE, SHALL register MEM_READDATA into CPU_READDATA; CPU_READDATA SHALL otherwise hold its value.
REQ-011 *_DONE SHALL last exactly one cycle, then go to IDLE.
REQ-012 CPU_BUSYWAIT SHALL equal CPU_READ && state!=CPU_DONE, combinationally; LD_BUSYWAIT SHALL equal LD_WRITE && state!=LD_DONE.
REQ-013 Minimum transaction latency: request in cycle 0, strobe in cycle 1, BUSYWAIT low in cycle 2 when the memory does not stall.
REQ-014 A requester that drops its request mid-access SHALL not abort the access; the memory cycle SHALL complete, CPU_READDATA SHALL still update, and no stall SHALL be reported.
REQ-015 Changes to CPU_ADDRESS, LD_ADDRESS or LD_WRITEDATA after a grant SHALL not affect the access in progress.
REQ-016 A request still high in *_DONE SHALL not be re-granted; it SHALL be treated as a new request only from IDLE, so at most one access is made per request cycle.
REQ-017 A losing requester SHALL stay stalled until its own *_DONE, which bounds its wait to one transaction.

Reset
REQ-018 RESET high SHALL immediately force:
  state=IDLE, last_grant=LOADER;
  MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, CPU_READDATA=0;
  CPU_BUSYWAIT=CPU_READ, LD_BUSYWAIT=LD_WRITE.
REQ-019 RESET asserted mid-access SHALL abandon the access with no data update; arbitration SHALL restart from IDLE on the first edge after release.

Verification
REQ-020 CPU_READ=1, CPU_ADDRESS=0x00000006, zero-wait memory returning 0x02060405 -> MEM_ADDRESS=0x00000004 and MEM_READ=1 in cycle 1; CPU_READDATA=0x02060405 and CPU_BUSYWAIT=0 in cycle 2.
REQ-021 LD_WRITE=1, LD_ADDRESS=0x10, LD_WRITEDATA=0x00040019, MEM_BUSYWAIT high for 3 cycles -> MEM_WRITE=1 for 4 cycles; LD_BUSYWAIT low in cycle 5 only.
REQ-022 CPU_READ and LD_WRITE rise together after reset and are held -> CPU served first, loader next, CPU third; grants strictly alternate and MEM_READ/MEM_WRITE never overlap.
REQ-023 CPU_ADDRESS changes 0x8->0xC while in CPU_ACC with MEM_BUSYWAIT=1 -> MEM_ADDRESS stays 0x8 until CPU_DONE.
REQ-024 RESET pulsed during LD_ACC -> MEM_WRITE=0 in the same cycle, state=IDLE, and a fresh LD_WRITE after release is granted after 1 cycle.
